// File: rtl/multicycle_seq_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_seq_ctrl : control sequencer for a multicycle MIPS-subset core
// Revision 1.0 - initial release
// ============================================================================
module multicycle_seq_ctrl #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic [5:0]       Op,
  input  logic             Mem_Ready,
  input  logic             Zero,
  output logic             PC_En,
  output logic             IR_En,
  output logic             AB_En,
  output logic             ALUOut_En,
  output logic             MDR_En,
  output logic             Reg_Wr,
  output logic             Mem_Rd,
  output logic             Mem_Wr,
  output logic             IorD,
  output logic [1:0]       PC_Src,
  output logic             RegDst,
  output logic             MemToReg,
  output logic [1:0]       ALU_Op,
  output logic [1:0]       ALUSrcB,
  output logic             Illegal,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] Instr_Cnt
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             illegal_q;
  logic             rdy;
  logic             exe_op;

  assign rdy    = (MEM_HANDSHAKE != 0) ? Mem_Ready : 1'b1;
  assign exe_op = (Op == OP_R) || (Op == OP_ADDI) || (Op == OP_LW) ||
                  (Op == OP_SW) || (Op == OP_BEQ);

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state     <= S_IF;
      cnt       <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_IF: if (rdy) state <= S_ID;
        S_ID: begin
          if (Op == OP_J) begin
            state <= S_IF;
            cnt   <= cnt + CNT_ONE;
          end else if (exe_op) begin
            state <= S_EXE;
          end else begin
            state     <= S_HALT;
            illegal_q <= 1'b1;
          end
        end
        S_EXE: begin
          case (Op)
            OP_R, OP_ADDI: state <= S_WB;
            OP_LW, OP_SW:  state <= S_MEM;
            OP_BEQ: begin
              state <= S_IF;
              cnt   <= cnt + CNT_ONE;
            end
            default:       state <= S_IF;
          endcase
        end
        S_MEM: begin
          if (rdy) begin
            if (Op == OP_SW) begin
              state <= S_IF;
              cnt   <= cnt + CNT_ONE;
            end else begin
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          state <= S_IF;
          cnt   <= cnt + CNT_ONE;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  always_comb begin
    PC_En     = 1'b0;
    IR_En     = 1'b0;
    AB_En     = 1'b0;
    ALUOut_En = 1'b0;
    MDR_En    = 1'b0;
    Reg_Wr    = 1'b0;
    Mem_Rd    = 1'b0;
    Mem_Wr    = 1'b0;
    IorD      = 1'b0;
    PC_Src    = 2'b00;
    RegDst    = 1'b0;
    MemToReg  = 1'b0;
    ALU_Op    = 2'b00;
    ALUSrcB   = 2'b00;
    case (state)
      S_IF: begin
        Mem_Rd  = 1'b1;
        ALUSrcB = 2'b01;
        IR_En   = rdy;
        PC_En   = rdy;
      end
      S_ID: begin
        AB_En     = 1'b1;
        ALUOut_En = 1'b1;
        ALUSrcB   = 2'b11;
        if (Op == OP_J) begin
          PC_En  = 1'b1;
          PC_Src = 2'b10;
        end
      end
      S_EXE: begin
        case (Op)
          OP_R: begin
            ALU_Op    = 2'b10;
            ALUOut_En = 1'b1;
          end
          OP_ADDI, OP_LW, OP_SW: begin
            ALUSrcB   = 2'b10;
            ALUOut_En = 1'b1;
          end
          OP_BEQ: begin
            ALU_Op = 2'b01;
            PC_Src = 2'b01;
            PC_En  = Zero;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        IorD = 1'b1;
        if (Op == OP_SW) begin
          Mem_Wr = 1'b1;
        end else begin
          Mem_Rd = 1'b1;
          MDR_En = rdy;
        end
      end
      S_WB: begin
        Reg_Wr   = 1'b1;
        RegDst   = (Op == OP_R);
        MemToReg = (Op == OP_LW);
      end
      default: ;
    endcase
    // Reset must never let a datapath register load or a memory access start.
    if (!Clrn) begin
      PC_En     = 1'b0;
      IR_En     = 1'b0;
      AB_En     = 1'b0;
      ALUOut_En = 1'b0;
      MDR_En    = 1'b0;
      Reg_Wr    = 1'b0;
      Mem_Rd    = 1'b0;
      Mem_Wr    = 1'b0;
    end
  end

  assign State     = state;
  assign Instr_Cnt = cnt;
  assign Illegal   = illegal_q;

endmodule
`default_nettype wire
